// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry, pixel record, arbiter FSM encodings.
// Used by the write arbiter and by the object FSMs that feed it.
package vga_pkg;

  localparam int nX          = 10;
  localparam int nY          = 9;
  localparam int COLOR_DEPTH = 9;
  localparam int XSCREEN     = 640;
  localparam int YSCREEN     = 480;

  typedef struct packed {
    logic [nX-1:0]          x;
    logic [nY-1:0]          y;
    logic [COLOR_DEPTH-1:0] color;
  } pixel_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Client-side request/pixel bundle plus the arbitrated VGA adapter port.
// master: drawing objects side; slave: the arbiter.
interface vga_write_arbiter_if #(
  parameter int N_CLIENTS   = 4,
  parameter int nX          = vga_pkg::nX,
  parameter int nY          = vga_pkg::nY,
  parameter int COLOR_DEPTH = vga_pkg::COLOR_DEPTH
);
  logic [N_CLIENTS-1:0]             req;
  logic [N_CLIENTS-1:0]             px_valid;
  logic [N_CLIENTS*nX-1:0]          x_in;
  logic [N_CLIENTS*nY-1:0]          y_in;
  logic [N_CLIENTS*COLOR_DEPTH-1:0] color_in;
  logic [N_CLIENTS-1:0]             gnt;
  logic [nX-1:0]                    VGA_x;
  logic [nY-1:0]                    VGA_y;
  logic [COLOR_DEPTH-1:0]           VGA_color;
  logic                             VGA_write;
  logic                             busy;

  modport master (
    output req, px_valid, x_in, y_in, color_in,
    input  gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy
  );

  modport slave (
    input  req, px_valid, x_in, y_in, color_in,
    output gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req after last_owner, wrapping.
// Outputs the winner as one-hot and as an index, plus an any-request flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest slot to the nearest so the nearest set request wins.
  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = N; k >= 1; k--) begin
      j = int'(last_owner) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (req[j[IDX_W-1:0]]) begin
        onehot                 = '0;
        onehot[j[IDX_W-1:0]]   = 1'b1;
        idx                    = j[IDX_W-1:0];
        any                    = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin, burst-granular arbiter for the single VGA adapter write port.
// Optional forced release after MAX_BURST pixels: define VGA_ARB_BURST_LIMIT_EN.
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int N_CLIENTS   = 4,
  parameter int nX          = vga_pkg::nX,
  parameter int nY          = vga_pkg::nY,
  parameter int COLOR_DEPTH = vga_pkg::COLOR_DEPTH,
  parameter int MAX_BURST   = 3600,
  parameter int CNT_W       = 12
) (
  input logic          Clock,
  input logic          Resetn,
  vga_write_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_CLIENTS);

  if (N_CLIENTS < 2 || N_CLIENTS > 8 || (2 ** CNT_W) <= MAX_BURST) begin : g_cfg_check
    $error("vga_write_arbiter: unsupported N_CLIENTS/MAX_BURST/CNT_W combination");
  end

  logic [0:0]             state_q,      state_d;
  logic [IDX_W-1:0]       owner_q,      owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic [N_CLIENTS-1:0]   gnt_q,        gnt_d;
  logic [nX-1:0]          x_q,          x_d;
  logic [nY-1:0]          y_q,          y_d;
  logic [COLOR_DEPTH-1:0] color_q,      color_d;
  logic                   write_q,      write_d;
  logic                   busy_q,       busy_d;

  logic [N_CLIENTS-1:0]   pick_onehot_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_any_s;

  logic                   own_req_s;
  logic                   own_px_s;
  logic [nX-1:0]          own_x_s;
  logic [nY-1:0]          own_y_s;
  logic [COLOR_DEPTH-1:0] own_color_s;
  logic                   force_rel_s;

  rr_pick #(.N(N_CLIENTS), .IDX_W(IDX_W)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .onehot     (pick_onehot_s),
    .idx        (pick_idx_s),
    .any        (pick_any_s)
  );

  // Select the current owner's request, strobe and pixel fields.
  always_comb begin
    own_req_s   = 1'b0;
    own_px_s    = 1'b0;
    own_x_s     = '0;
    own_y_s     = '0;
    own_color_s = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_req_s   = bus.req[i];
        own_px_s    = bus.px_valid[i];
        own_x_s     = bus.x_in[i*nX +: nX];
        own_y_s     = bus.y_in[i*nY +: nY];
        own_color_s = bus.color_in[i*COLOR_DEPTH +: COLOR_DEPTH];
      end else begin
        own_req_s = own_req_s;
      end
    end
  end

`ifdef VGA_ARB_BURST_LIMIT_EN
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_inc_s;

  // Preempt once this cycle's pixel brings the burst to MAX_BURST and someone else waits.
  always_comb begin
    if (own_px_s && (burst_cnt_q != {CNT_W{1'b1}})) begin
      burst_inc_s = burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      burst_inc_s = burst_cnt_q;
    end
    force_rel_s = (burst_inc_s >= CNT_W'(MAX_BURST)) && (|(bus.req & ~gnt_q));
  end
`else
  assign force_rel_s = 1'b0;
`endif

  // Next-state logic for grant ownership and the registered pixel port.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    write_d      = 1'b0;
    busy_d       = busy_q;
`ifdef VGA_ARB_BURST_LIMIT_EN
    burst_cnt_d  = burst_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d = ST_GRANT;
          owner_d = pick_idx_s;
          gnt_d   = pick_onehot_s;
          busy_d  = 1'b1;
`ifdef VGA_ARB_BURST_LIMIT_EN
          burst_cnt_d = '0;
`endif
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (own_px_s) begin
          x_d     = own_x_s;
          y_d     = own_y_s;
          color_d = own_color_s;
          write_d = 1'b1;
        end else begin
          write_d = 1'b0;
        end
`ifdef VGA_ARB_BURST_LIMIT_EN
        burst_cnt_d = burst_inc_s;
`endif
        // Releasing client becomes last_owner so it is scanned last next time.
        if (!own_req_s || force_rel_s) begin
          state_d      = ST_IDLE;
          gnt_d        = '0;
          busy_d       = 1'b0;
          last_owner_d = owner_q;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_CLIENTS - 1);
      gnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef VGA_ARB_BURST_LIMIT_EN
      burst_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      write_q      <= write_d;
      busy_q       <= busy_d;
`ifdef VGA_ARB_BURST_LIMIT_EN
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.VGA_x     = x_q;
  assign bus.VGA_y     = y_q;
  assign bus.VGA_color = color_q;
  assign bus.VGA_write = write_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: fixed vector table, directed burst scenarios and
// random traffic checked against a cycle-level behavioural model.
module tb_vga_write_arbiter;

  localparam int  N   = 4;
  localparam int  NXW = 10;
  localparam int  NYW = 9;
  localparam int  CD  = 9;
  localparam int  MAXB = 16;
`ifdef VGA_ARB_BURST_LIMIT_EN
  localparam bit  LIMIT = 1'b1;
`else
  localparam bit  LIMIT = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  vga_write_arbiter_if #(.N_CLIENTS(N), .nX(NXW), .nY(NYW), .COLOR_DEPTH(CD)) bus ();

  vga_write_arbiter #(
    .N_CLIENTS(N), .nX(NXW), .nY(NYW), .COLOR_DEPTH(CD), .MAX_BURST(MAXB), .CNT_W(12)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [NXW-1:0] xs [N];
  logic [NYW-1:0] ys [N];
  logic [CD-1:0]  cs [N];

  // behavioural model: owner = -1 when the port is free
  int             m_owner, m_last, m_cnt;
  logic [N-1:0]   m_gnt;
  logic [NXW-1:0] m_x;
  logic [NYW-1:0] m_y;
  logic [CD-1:0]  m_c;
  logic           m_wr, m_busy;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      bus.x_in[i*NXW +: NXW]  = xs[i];
      bus.y_in[i*NYW +: NYW]  = ys[i];
      bus.color_in[i*CD +: CD] = cs[i];
    end
  endtask

  task automatic model_step();
    int o;
    bit others;
    if (!Resetn) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0;
      m_x = '0; m_y = '0; m_c = '0; m_wr = 1'b0;
    end else if (m_owner < 0) begin
      m_wr = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && bus.req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_cnt   = 0;
        end
      end
    end else begin
      o = m_owner;
      if (bus.px_valid[o]) begin
        m_x = xs[o]; m_y = ys[o]; m_c = cs[o]; m_wr = 1'b1; m_cnt++;
      end else begin
        m_wr = 1'b0;
      end
      others = 1'b0;
      for (int i = 0; i < N; i++) if (i != o && bus.req[i]) others = 1'b1;
      if (!bus.req[o] || (LIMIT && m_cnt >= MAXB && others)) begin
        m_last  = o;
        m_owner = -1;
      end
    end
    m_gnt  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    m_busy = (m_owner >= 0);
  endtask

  task automatic cycle();
    drive_fields();
    model_step();
    @(posedge Clock);
    #1;
    check("gnt",   bus.gnt,       m_gnt);
    check("write", bus.VGA_write, m_wr);
    check("busy",  bus.busy,      m_busy);
    check("x",     bus.VGA_x,     m_x);
    check("y",     bus.VGA_y,     m_y);
    check("color", bus.VGA_color, m_c);
  endtask

  typedef struct {
    logic         rstn;
    logic [N-1:0] req;
    logic [N-1:0] px;
    logic [N-1:0] gnt;
    logic         wr;
    logic         busy;
    int           src;   // client whose pixel is on VGA_x; -1 skip, -2 expect zero
  } vec_t;

  vec_t tbl [14];
  int   wr_count;
  int   hold_cnt;

  initial begin
    Resetn = 1'b0;
    bus.req = '0;
    bus.px_valid = '0;
    for (int i = 0; i < N; i++) begin
      xs[i] = NXW'(100 + i*7);
      ys[i] = NYW'(50 + i);
      cs[i] = CD'(16 + i);
    end
    drive_fields();

    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, -2};
    tbl[1]  = '{1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b0, 1'b1, -1};
    tbl[2]  = '{1'b1, 4'b0101, 4'b0001, 4'b0001, 1'b1, 1'b1,  0};
    tbl[3]  = '{1'b1, 4'b0100, 4'b0001, 4'b0000, 1'b1, 1'b0,  0};
    tbl[4]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, -1};
    tbl[5]  = '{1'b1, 4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b1,  2};
    tbl[6]  = '{1'b1, 4'b0001, 4'b0101, 4'b0000, 1'b1, 1'b0,  2};
    tbl[7]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, -1};
    tbl[8]  = '{1'b1, 4'b0001, 4'b1000, 4'b0001, 1'b0, 1'b1, -1};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, -2};
    tbl[10] = '{1'b1, 4'b1110, 4'b0000, 4'b0010, 1'b0, 1'b1, -1};
    tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, -1};
    tbl[12] = '{1'b1, 4'b1010, 4'b0000, 4'b1000, 1'b0, 1'b1, -1};
    tbl[13] = '{1'b1, 4'b1010, 4'b1010, 4'b1000, 1'b1, 1'b1,  3};

    for (int v = 0; v < 14; v++) begin
      Resetn       = tbl[v].rstn;
      bus.req      = tbl[v].req;
      bus.px_valid = tbl[v].px;
      @(posedge Clock);
      #1;
      check($sformatf("tbl%0d_gnt", v),   bus.gnt,       tbl[v].gnt);
      check($sformatf("tbl%0d_write", v), bus.VGA_write, tbl[v].wr);
      check($sformatf("tbl%0d_busy", v),  bus.busy,      tbl[v].busy);
      if (tbl[v].src >= 0) check($sformatf("tbl%0d_x", v), bus.VGA_x, xs[tbl[v].src]);
      else if (tbl[v].src == -2) check($sformatf("tbl%0d_x0", v), bus.VGA_x, 0);
    end

    // Long single-client burst: every px_valid yields exactly one write.
    Resetn = 1'b0; bus.req = '0; bus.px_valid = '0; cycle();
    Resetn = 1'b1; bus.req = 4'b0001; cycle();
    check("t1_gnt_first", bus.gnt, 4'b0001);
    wr_count = 0;
    for (int p = 0; p < 3600; p++) begin
      bus.px_valid = 4'b0001;
      xs[0] = NXW'(p % 640); ys[0] = NYW'(p % 480); cs[0] = CD'(p % 512);
      cycle();
      if (bus.VGA_write) wr_count++;
    end
    bus.px_valid = '0; bus.req = '0; cycle();
    if (bus.VGA_write) wr_count++;
    check("t1_writes", wr_count, 3600);
    check("t1_gnt_released", bus.gnt, 4'b0000);

    // Non-owner pixels never reach the adapter.
    Resetn = 1'b0; cycle();
    Resetn = 1'b1; bus.req = 4'b1010; cycle();
    check("t3_gnt1", bus.gnt, 4'b0010);
    xs[3] = NXW'(700);
    for (int p = 0; p < 20; p++) begin
      xs[1] = NXW'(p);
      bus.px_valid = {1'b1, 1'b0, p[0], 1'b0};
      cycle();
      check("t3_no_client3", (bus.VGA_x == NXW'(700)), 0);
    end
    bus.req = '0; bus.px_valid = '0; cycle(); cycle();

    // Reset in mid-burst drops everything; client 0 wins afterwards.
    Resetn = 1'b0; cycle();
    Resetn = 1'b1; bus.req = 4'b0100; cycle();
    for (int p = 0; p < 100; p++) begin
      bus.px_valid = 4'b0100; xs[2] = NXW'(p); cycle();
    end
    Resetn = 1'b0; cycle();
    check("t4_gnt", bus.gnt, 4'b0000);
    check("t4_write", bus.VGA_write, 0);
    check("t4_busy", bus.busy, 0);
    Resetn = 1'b1; bus.req = 4'b1111; bus.px_valid = '0; cycle();
    check("t4_client0_first", bus.gnt, 4'b0001);
    bus.req = '0; cycle(); cycle();

    // Two requesters, client 0 streaming without pause.
    Resetn = 1'b0; cycle();
    Resetn = 1'b1; bus.req = 4'b0011; bus.px_valid = '0; cycle();
    check("t5_gnt0", bus.gnt, 4'b0001);
    wr_count = 0;
    for (int p = 0; p < MAXB; p++) begin
      bus.px_valid = 4'b0011; xs[0] = NXW'(200 + p); cycle();
      if (bus.VGA_write) wr_count++;
    end
    check("t5_writes", wr_count, MAXB);
`ifdef VGA_ARB_BURST_LIMIT_EN
    check("t5_preempted", bus.gnt, 4'b0000);
    bus.px_valid = 4'b0000; cycle();
    check("t5_gnt1", bus.gnt, 4'b0010);
    for (int p = 0; p < 5; p++) begin
      bus.px_valid = 4'b0010; xs[1] = NXW'(300 + p); cycle();
    end
    bus.req = 4'b0001; bus.px_valid = '0; cycle();
    check("t5_rel1", bus.gnt, 4'b0000);
    cycle();
    check("t5_regrant0", bus.gnt, 4'b0001);
`else
    hold_cnt = 0;
    for (int p = 0; p < 30; p++) begin
      bus.px_valid = 4'b0011; cycle();
      if (bus.gnt == 4'b0001) hold_cnt++;
    end
    check("t6_held", hold_cnt, 30);
    bus.req = 4'b0010; bus.px_valid = '0; cycle();
    check("t6_rel0", bus.gnt, 4'b0000);
    cycle();
    check("t6_gnt1", bus.gnt, 4'b0010);
`endif
    bus.req = '0; bus.px_valid = '0; cycle(); cycle();

    // Random traffic against the model.
    Resetn = 1'b0; cycle();
    Resetn = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req[i]) begin
          if ($urandom_range(19, 0) == 0) bus.req[i] = 1'b0;
        end else begin
          if ($urandom_range(7, 0) == 0) bus.req[i] = 1'b1;
        end
        bus.px_valid[i] = 1'($urandom_range(1, 0));
        xs[i] = NXW'($urandom); ys[i] = NYW'($urandom); cs[i] = CD'($urandom);
      end
      Resetn = ($urandom_range(499, 0) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
